operand_access_ctrl: RTL and testbench
======================================

OPERAND_ACCESS_CTRL -- requirements
Module: operand_access_ctrl

Interface
REQ-001 The module SHALL have the parameter IDLE_ADDR, default 32'h0000_0000, which is the value driven on waddr/raddr1/raddr2 when no access is active and which matches no mapped address.
REQ-002 The module SHALL have the parameter WAIT_CYCLES, default 1 (range 1..15), which is the number of cycles the read addresses are held after issue before read data is captured.
REQ-003 The module SHALL have the port PCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The module SHALL have the port PRESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have the command ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 3 (000 write A, 001 write B, 010 read bank0, 011 read bank1, 1xx illegal); cmd_wdata in 16.
REQ-006 The module SHALL have the memory-side ports: waddr out 32; wdata out 32; raddr1 out 32; raddr2 out 32; mem_read_data1 in 16; mem_read_data2 in 16.
REQ-007 The module SHALL have the response ports: rsp_valid out 1; rsp_ready in 1; rsp_data1 out 16; rsp_data2 out 16; busy out 1.

Function
REQ-008 The state machine SHALL have the states IDLE, WRITE, RD_ISSUE, RD_WAIT and RESP.
REQ-009 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid & cmd_ready; busy = (state != IDLE).
REQ-010 On accepting write A or write B, the module SHALL go IDLE->WRITE and, for exactly one cycle, drive waddr = 32'h1111_0000 (A) or 32'h2111_0000 (B) and wdata = {16'h0000, cmd_wdata}, then return to IDLE; a write produces no response.
REQ-011 On accepting read bank0, the module SHALL drive raddr1 = 32'h1211_1111 and raddr2 = 32'h1312_2222; for read bank1 it SHALL drive 32'h2211_1111 and 32'h2312_2222.
REQ-012 The read addresses SHALL be held through RD_ISSUE (1 cycle) and RD_WAIT (WAIT_CYCLES cycles, counted by a 4-bit down-counter).
REQ-013 On the edge that leaves the last RD_WAIT cycle, the module SHALL capture mem_read_data1/2 into rsp_data1/2 and enter RESP; with WAIT_CYCLES=1, rsp_valid rises 3 edges after the acceptance edge.
REQ-014 In RESP, rsp_valid SHALL be 1 and rsp_data SHALL be stable until rsp_valid & rsp_ready, after which the module returns to IDLE.
REQ-015 No new command SHALL be accepted while rsp_valid = 1 (no skid).
REQ-016 Any address output not actively used in the current state SHALL equal IDLE_ADDR, and wdata SHALL be 0 outside WRITE.
REQ-017 cmd_op, cmd_wdata and the bank select SHALL be registered at acceptance; input changes after acceptance SHALL have no effect.
REQ-018 An illegal cmd_op SHALL be accepted, cause no memory access, and leave the state in IDLE, except as extended by the configuration below.

Reset
REQ-019 While PRESET = 1 at a rising edge, the module SHALL set state = IDLE, waddr = raddr1 = raddr2 = IDLE_ADDR, wdata = 0, rsp_valid = 0, rsp_data1 = rsp_data2 = 0, the wait counter to 0, and err (if present) to 0.
REQ-020 A reset asserted mid-write or mid-read SHALL abort the access and drop any pending response; cmd_ready SHALL be 1 on the first cycle after PRESET deasserts.

Configuration
REQ-021 The macro OPACC_ERR_EN SHALL control illegal-command reporting.
REQ-022 With OPACC_ERR_EN defined, the module SHALL have an extra port err (out, 1 bit), and an illegal cmd_op SHALL go to RESP with rsp_data1 = rsp_data2 = 16'hDEAD and err = 1 for as long as rsp_valid is 1.
REQ-023 Without OPACC_ERR_EN, the err port SHALL be absent and illegal commands SHALL be silently dropped as in REQ-018.

Structure
REQ-024 A shared package SHALL hold the six memory map constants (1111_0000, 2111_0000, 1211_1111, 1312_2222, 2211_1111, 2312_2222), the cmd_op encoding enum, and the state enum.
REQ-025 The module SHALL be a single module with no sub-module; the bench SHALL instantiate it against memorymodule-equivalent memory behaviour.

Verification
REQ-026 After reset, read bank0 then accept rsp -> rsp_data1 = 16'h0011 and rsp_data2 = 16'h0111; rsp_valid rises 3 edges after acceptance.
REQ-027 Write A with 16'hBEEF -> waddr = 32'h1111_0000 and wdata = 32'h0000_BEEF for exactly 1 cycle, then IDLE_ADDR; no rsp_valid.
REQ-028 Read bank1 with rsp_ready held at 0 for 5 cycles -> rsp_valid stays 1, rsp_data = 16'h1111/16'h1011 stable, cmd_ready = 0; the response completes on rsp_ready = 1.
REQ-029 Assert PRESET during RD_WAIT -> the next cycle shows rsp_valid = 0, addresses = IDLE_ADDR and cmd_ready = 1.
REQ-030 cmd_op = 3'b100: with OPACC_ERR_EN -> rsp 16'hDEAD and err = 1; without OPACC_ERR_EN -> no response, and addresses stay IDLE_ADDR.
REQ-031 With WAIT_CYCLES = 3 and back-to-back read bank0 / read bank1 commands -> each response arrives 5 edges after its acceptance, with the correct data for each.

Source files
------------

// File: rtl/operand_access_ctrl_pkg.sv
// Shared memory map, command encoding and FSM states for operand_access_ctrl.
package operand_access_ctrl_pkg;

  localparam logic [31:0] AddrWrA  = 32'h1111_0000;
  localparam logic [31:0] AddrWrB  = 32'h2111_0000;
  localparam logic [31:0] AddrRd0A = 32'h1211_1111;
  localparam logic [31:0] AddrRd0B = 32'h1312_2222;
  localparam logic [31:0] AddrRd1A = 32'h2211_1111;
  localparam logic [31:0] AddrRd1B = 32'h2312_2222;

  typedef enum logic [2:0] {
    OpWrA  = 3'b000,
    OpWrB  = 3'b001,
    OpRdB0 = 3'b010,
    OpRdB1 = 3'b011
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdIssue,
    StRdWait,
    StResp
  } state_e;

endpackage

// File: rtl/operand_access_ctrl.sv
// Command-driven operand write/read sequencer in front of a two-port memory.
// Define OPACC_ERR_EN to report illegal commands as a 16'hDEAD response with err set.
module operand_access_ctrl
  import operand_access_ctrl_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_wdata,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic [31:0] raddr1,
  output logic [31:0] raddr2,
  input  logic [15:0] mem_read_data1,
  input  logic [15:0] mem_read_data2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data1,
  output logic [15:0] rsp_data2,
  output logic        busy
`ifdef OPACC_ERR_EN
  ,
  output logic        err
`endif
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] raddr1_q, raddr1_d;
  logic [31:0] raddr2_q, raddr2_d;
  logic [15:0] rsp_data1_q, rsp_data1_d;
  logic [15:0] rsp_data2_q, rsp_data2_d;
`ifdef OPACC_ERR_EN
  logic        err_q, err_d;
`endif

  // Addresses and write data are registered at acceptance, so later input changes are ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    raddr1_d    = raddr1_q;
    raddr2_d    = raddr2_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;
`ifdef OPACC_ERR_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_op)
            OpWrA, OpWrB: begin
              state_d = StWrite;
              waddr_d = (cmd_op == OpWrB) ? AddrWrB : AddrWrA;
              wdata_d = {16'h0000, cmd_wdata};
            end
            OpRdB0: begin
              state_d  = StRdIssue;
              raddr1_d = AddrRd0A;
              raddr2_d = AddrRd0B;
            end
            OpRdB1: begin
              state_d  = StRdIssue;
              raddr1_d = AddrRd1A;
              raddr2_d = AddrRd1B;
            end
            default: begin
`ifdef OPACC_ERR_EN
              state_d     = StResp;
              rsp_data1_d = 16'hDEAD;
              rsp_data2_d = 16'hDEAD;
              err_d       = 1'b1;
`endif
            end
          endcase
        end
      end
      StWrite: begin
        state_d = StIdle;
        waddr_d = IDLE_ADDR;
        wdata_d = 32'h0;
      end
      StRdIssue: begin
        state_d = StRdWait;
        cnt_d   = WaitInit;
      end
      StRdWait: begin
        if (cnt_q <= 4'd1) begin
          state_d     = StResp;
          cnt_d       = 4'd0;
          rsp_data1_d = mem_read_data1;
          rsp_data2_d = mem_read_data2;
          raddr1_d    = IDLE_ADDR;
          raddr2_d    = IDLE_ADDR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
`ifdef OPACC_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      waddr_q     <= IDLE_ADDR;
      wdata_q     <= 32'h0;
      raddr1_q    <= IDLE_ADDR;
      raddr2_q    <= IDLE_ADDR;
      rsp_data1_q <= 16'h0;
      rsp_data2_q <= 16'h0;
`ifdef OPACC_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr1_q    <= raddr1_d;
      raddr2_q    <= raddr2_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
`ifdef OPACC_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign raddr1    = raddr1_q;
  assign raddr2    = raddr2_q;
  assign rsp_data1 = rsp_data1_q;
  assign rsp_data2 = rsp_data2_q;
`ifdef OPACC_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_operand_access_ctrl.sv
// Bench for operand_access_ctrl: instance 0 uses WAIT_CYCLES=1, instance 1 uses WAIT_CYCLES=3.
module tb_operand_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a       [2];
  logic        cmd_valid_a [2];
  logic [2:0]  cmd_op_a    [2];
  logic [15:0] cmd_wdata_a [2];
  logic        rsp_ready_a [2];
  logic        cmd_ready_a [2];
  logic        rsp_valid_a [2];
  logic        busy_a      [2];
  logic [31:0] waddr_a     [2];
  logic [31:0] wdata_a     [2];
  logic [31:0] raddr1_a    [2];
  logic [31:0] raddr2_a    [2];
  logic [15:0] mem1_a      [2];
  logic [15:0] mem2_a      [2];
  logic [15:0] rsp1_a      [2];
  logic [15:0] rsp2_a      [2];
`ifdef OPACC_ERR_EN
  logic        err_a       [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic int wait_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] idle_of(int k);
    return (k == 0) ? 32'h0000_0000 : 32'hDEAD_0000;
  endfunction

  // Fixed-content memory: each mapped read address returns its own operand word.
  function automatic logic [15:0] mem_lookup(logic [31:0] a);
    case (a)
      32'h1211_1111: return 16'h0011;
      32'h1312_2222: return 16'h0111;
      32'h2211_1111: return 16'h1111;
      32'h2312_2222: return 16'h1011;
      default:       return 16'hBAD0;
    endcase
  endfunction

  assign mem1_a[0] = mem_lookup(raddr1_a[0]);
  assign mem2_a[0] = mem_lookup(raddr2_a[0]);
  assign mem1_a[1] = mem_lookup(raddr1_a[1]);
  assign mem2_a[1] = mem_lookup(raddr2_a[1]);

  operand_access_ctrl #(.IDLE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u0 (
    .PCLK(clk), .PRESET(rst_a[0]),
    .cmd_valid(cmd_valid_a[0]), .cmd_ready(cmd_ready_a[0]),
    .cmd_op(cmd_op_a[0]), .cmd_wdata(cmd_wdata_a[0]),
    .waddr(waddr_a[0]), .wdata(wdata_a[0]), .raddr1(raddr1_a[0]), .raddr2(raddr2_a[0]),
    .mem_read_data1(mem1_a[0]), .mem_read_data2(mem2_a[0]),
    .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]),
    .rsp_data1(rsp1_a[0]), .rsp_data2(rsp2_a[0]), .busy(busy_a[0])
`ifdef OPACC_ERR_EN
    , .err(err_a[0])
`endif
  );

  operand_access_ctrl #(.IDLE_ADDR(32'hDEAD_0000), .WAIT_CYCLES(3)) u1 (
    .PCLK(clk), .PRESET(rst_a[1]),
    .cmd_valid(cmd_valid_a[1]), .cmd_ready(cmd_ready_a[1]),
    .cmd_op(cmd_op_a[1]), .cmd_wdata(cmd_wdata_a[1]),
    .waddr(waddr_a[1]), .wdata(wdata_a[1]), .raddr1(raddr1_a[1]), .raddr2(raddr2_a[1]),
    .mem_read_data1(mem1_a[1]), .mem_read_data2(mem2_a[1]),
    .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]),
    .rsp_data1(rsp1_a[1]), .rsp_data2(rsp2_a[1]), .busy(busy_a[1])
`ifdef OPACC_ERR_EN
    , .err(err_a[1])
`endif
  );

  task automatic chk(int k, string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d.%s: got %h, expected %h (t=%0t)", k, name, act, exp, $time);
    end
  endtask

  // Transaction model: kind 0 idle, 1 write cycle, 2 read (age = cycles since acceptance),
  // 3 error response. Read addresses are live for ages 0..W, the response from age W+1.
  int          m_kind  [2];
  int          m_age   [2];
  logic        m_bank  [2];
  logic [31:0] m_waddr [2];
  logic [31:0] m_wdata [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_kind[k] = 0; m_age[k] = 0; m_bank[k] = 1'b0;
      m_waddr[k] = 32'h0; m_wdata[k] = 32'h0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_a[k]) begin
        m_kind[k] <= 0;
      end else begin
        case (m_kind[k])
          0: if (cmd_valid_a[k]) begin
            if (cmd_op_a[k] == 3'b000 || cmd_op_a[k] == 3'b001) begin
              m_kind[k]  <= 1;
              m_waddr[k] <= cmd_op_a[k][0] ? 32'h2111_0000 : 32'h1111_0000;
              m_wdata[k] <= {16'h0000, cmd_wdata_a[k]};
            end else if (cmd_op_a[k] == 3'b010 || cmd_op_a[k] == 3'b011) begin
              m_kind[k] <= 2;
              m_age[k]  <= 0;
              m_bank[k] <= cmd_op_a[k][0];
            end else begin
`ifdef OPACC_ERR_EN
              m_kind[k] <= 3;
`endif
            end
          end
          1: m_kind[k] <= 0;
          2: begin
            m_age[k] <= m_age[k] + 1;
            if (m_age[k] >= wait_of(k) + 1 && rsp_ready_a[k]) m_kind[k] <= 0;
          end
          3: if (rsp_ready_a[k]) m_kind[k] <= 0;
          default: m_kind[k] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        exp_rsp, exp_rd;
    logic [15:0] e1, e2;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        exp_rd  = (m_kind[k] == 2) && (m_age[k] <= wait_of(k));
        exp_rsp = ((m_kind[k] == 2) && (m_age[k] > wait_of(k))) || (m_kind[k] == 3);
        chk(k, "cmd_ready", 32'(cmd_ready_a[k]), 32'(m_kind[k] == 0));
        chk(k, "busy", 32'(busy_a[k]), 32'(m_kind[k] != 0));
        chk(k, "rsp_valid", 32'(rsp_valid_a[k]), 32'(exp_rsp));
        chk(k, "waddr", waddr_a[k], (m_kind[k] == 1) ? m_waddr[k] : idle_of(k));
        chk(k, "wdata", wdata_a[k], (m_kind[k] == 1) ? m_wdata[k] : 32'h0);
        chk(k, "raddr1", raddr1_a[k],
            exp_rd ? (m_bank[k] ? 32'h2211_1111 : 32'h1211_1111) : idle_of(k));
        chk(k, "raddr2", raddr2_a[k],
            exp_rd ? (m_bank[k] ? 32'h2312_2222 : 32'h1312_2222) : idle_of(k));
        if (exp_rsp) begin
          if (m_kind[k] == 3) begin
            e1 = 16'hDEAD; e2 = 16'hDEAD;
          end else begin
            e1 = m_bank[k] ? 16'h1111 : 16'h0011;
            e2 = m_bank[k] ? 16'h1011 : 16'h0111;
          end
          chk(k, "rsp_data1", 32'(rsp1_a[k]), 32'(e1));
          chk(k, "rsp_data2", 32'(rsp2_a[k]), 32'(e2));
        end
`ifdef OPACC_ERR_EN
        chk(k, "err", 32'(err_a[k]), 32'(m_kind[k] == 3));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one command for a single edge, then scrambles the inputs it carried.
  task automatic issue(int k, logic [2:0] op, logic [15:0] wd);
    cmd_valid_a[k] = 1'b1;
    cmd_op_a[k]    = op;
    cmd_wdata_a[k] = wd;
    tick();
    cmd_valid_a[k] = 1'b0;
    cmd_op_a[k]    = 3'($urandom);
    cmd_wdata_a[k] = 16'($urandom);
  endtask

  // Edges counted include the acceptance edge itself.
  task automatic wait_rsp(int k, output int edges);
    edges = 1;
    while (rsp_valid_a[k] !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic handshake(int k);
    rsp_ready_a[k] = 1'b1;
    tick();
    rsp_ready_a[k] = 1'b0;
  endtask

  int e;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_a[k] = 1'b1; cmd_valid_a[k] = 1'b0; cmd_op_a[k] = 3'b000;
      cmd_wdata_a[k] = 16'h0; rsp_ready_a[k] = 1'b0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;

    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_cmd_ready", 32'(cmd_ready_a[k]), 32'd1);
      chk(k, "rst_rsp_valid", 32'(rsp_valid_a[k]), 32'd0);
      chk(k, "rst_raddr1", raddr1_a[k], idle_of(k));
      chk(k, "rst_wdata", wdata_a[k], 32'h0);
      chk(k, "rst_rsp_data1", 32'(rsp1_a[k]), 32'h0);
      chk(k, "rst_rsp_data2", 32'(rsp2_a[k]), 32'h0);
    end

    // Read bank0 with default wait
    issue(0, 3'b010, 16'h0);
    wait_rsp(0, e);
    chk(0, "rd0_latency_edges", 32'(e), 32'd3);
    chk(0, "rd0_data1", 32'(rsp1_a[0]), 32'h0011);
    chk(0, "rd0_data2", 32'(rsp2_a[0]), 32'h0111);
    handshake(0);
    chk(0, "rd0_done_valid", 32'(rsp_valid_a[0]), 32'd0);
    chk(0, "rd0_done_ready", 32'(cmd_ready_a[0]), 32'd1);

    // Write A, then write B
    issue(0, 3'b000, 16'hBEEF);
    chk(0, "wra_waddr", waddr_a[0], 32'h1111_0000);
    chk(0, "wra_wdata", wdata_a[0], 32'h0000_BEEF);
    tick();
    chk(0, "wra_after_waddr", waddr_a[0], 32'h0);
    chk(0, "wra_after_wdata", wdata_a[0], 32'h0);
    chk(0, "wra_no_rsp", 32'(rsp_valid_a[0]), 32'd0);
    issue(0, 3'b001, 16'h1234);
    chk(0, "wrb_waddr", waddr_a[0], 32'h2111_0000);
    chk(0, "wrb_wdata", wdata_a[0], 32'h0000_1234);
    repeat (2) tick();

    // Read bank1 with backpressure; a pending command must not be accepted
    issue(0, 3'b011, 16'h0);
    wait_rsp(0, e);
    chk(0, "rd1_latency_edges", 32'(e), 32'd3);
    cmd_valid_a[0] = 1'b1;
    cmd_op_a[0]    = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(0, "hold_valid", 32'(rsp_valid_a[0]), 32'd1);
      chk(0, "hold_data1", 32'(rsp1_a[0]), 32'h1111);
      chk(0, "hold_data2", 32'(rsp2_a[0]), 32'h1011);
      chk(0, "hold_cmd_ready", 32'(cmd_ready_a[0]), 32'd0);
    end
    cmd_valid_a[0] = 1'b0;
    handshake(0);
    chk(0, "hold_done_valid", 32'(rsp_valid_a[0]), 32'd0);
    chk(0, "hold_no_write", waddr_a[0], 32'h0);

    // Reset during the wait phase of a read
    issue(0, 3'b010, 16'h0);
    tick();
    chk(0, "midrd_raddr1", raddr1_a[0], 32'h1211_1111);
    rst_a[0] = 1'b1;
    tick();
    rst_a[0] = 1'b0;
    chk(0, "midrd_rst_valid", 32'(rsp_valid_a[0]), 32'd0);
    chk(0, "midrd_rst_raddr1", raddr1_a[0], 32'h0);
    chk(0, "midrd_rst_raddr2", raddr2_a[0], 32'h0);
    chk(0, "midrd_rst_ready", 32'(cmd_ready_a[0]), 32'd1);
    tick();
    chk(0, "midrd_dropped", 32'(rsp_valid_a[0]), 32'd0);

    // Reset during a write cycle
    issue(0, 3'b001, 16'h5555);
    rst_a[0] = 1'b1;
    tick();
    rst_a[0] = 1'b0;
    chk(0, "midwr_waddr", waddr_a[0], 32'h0);
    chk(0, "midwr_wdata", wdata_a[0], 32'h0);
    chk(0, "midwr_ready", 32'(cmd_ready_a[0]), 32'd1);

    // Illegal command
    issue(0, 3'b100, 16'h7777);
`ifdef OPACC_ERR_EN
    chk(0, "ill_valid", 32'(rsp_valid_a[0]), 32'd1);
    chk(0, "ill_data1", 32'(rsp1_a[0]), 32'hDEAD);
    chk(0, "ill_data2", 32'(rsp2_a[0]), 32'hDEAD);
    chk(0, "ill_err", 32'(err_a[0]), 32'd1);
    handshake(0);
    chk(0, "ill_err_clr", 32'(err_a[0]), 32'd0);
`else
    chk(0, "ill_no_rsp", 32'(rsp_valid_a[0]), 32'd0);
    chk(0, "ill_ready", 32'(cmd_ready_a[0]), 32'd1);
    chk(0, "ill_raddr1", raddr1_a[0], 32'h0);
    chk(0, "ill_waddr", waddr_a[0], 32'h0);
    tick();
    chk(0, "ill_still_no_rsp", 32'(rsp_valid_a[0]), 32'd0);
`endif
    tick();

    // Longer wait: back-to-back reads on the WAIT_CYCLES=3 instance
    issue(1, 3'b010, 16'h0);
    wait_rsp(1, e);
    chk(1, "w3_rd0_latency_edges", 32'(e), 32'd5);
    chk(1, "w3_rd0_data1", 32'(rsp1_a[1]), 32'h0011);
    chk(1, "w3_rd0_data2", 32'(rsp2_a[1]), 32'h0111);
    handshake(1);
    issue(1, 3'b011, 16'h0);
    wait_rsp(1, e);
    chk(1, "w3_rd1_latency_edges", 32'(e), 32'd5);
    chk(1, "w3_rd1_data1", 32'(rsp1_a[1]), 32'h1111);
    chk(1, "w3_rd1_data2", 32'(rsp2_a[1]), 32'h1011);
    handshake(1);
    chk(1, "w3_done_ready", 32'(cmd_ready_a[1]), 32'd1);
    chk(1, "w3_idle_raddr1", raddr1_a[1], 32'hDEAD_0000);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
